// File: rtl/retire_stage_if.sv
// Writeback, recall and retire bundle between the execution ports, rename and the retire stage.
// master: drives writebacks, the rename front pointer and recall; observes retire outputs and head.
// slave : the retire stage itself.
interface retire_stage_if #(
  parameter int AL_SIZE = 32
);
  localparam int P = $clog2(AL_SIZE);

  // Writeback ports: 0-1 arithmetic, 2-3 memory.
  logic [3:0]          wb_valid;
  logic [3:0][P-1:0]   wb_al_idx;
  logic [3:0]          wb_uses_rd;
  logic [3:0][4:0]     wb_rd;
  logic [3:0][31:0]    wb_data;

  // Rename / front-end control.
  logic [P-1:0]        al_front_ptr;
  logic                if_recall;
  logic [P-1:0]        new_front;

  // Retire slots: slot 0 is the older.
  logic [1:0]          ret_valid;
  logic [1:0][P-1:0]   ret_al_idx;
  logic [1:0]          ret_uses_rd;
  logic [1:0][4:0]     ret_rd;
  logic [1:0][31:0]    ret_data;
  logic [P-1:0]        al_back_ptr;

  modport master (
    output wb_valid, wb_al_idx, wb_uses_rd, wb_rd, wb_data,
    output al_front_ptr, if_recall, new_front,
    input  ret_valid, ret_al_idx, ret_uses_rd, ret_rd, ret_data, al_back_ptr
  );

  modport slave (
    input  wb_valid, wb_al_idx, wb_uses_rd, wb_rd, wb_data,
    input  al_front_ptr, if_recall, new_front,
    output ret_valid, ret_al_idx, ret_uses_rd, ret_rd, ret_data, al_back_ptr
  );
endinterface

// File: rtl/retire_stage.sv
// Active-list completion tracking and in-order retirement of up to two entries per cycle.
// Latency: a writeback captured at edge t is visible on ret_* after edge t+1; al_back_ptr is the registered head.
// Backpressure: none; writebacks are always accepted (dropped only if squashed) and retire is throttled by done bits.
// Ports: clk, reset (async, active-high), rs (retire_stage_if.slave: wb_*, al_front_ptr, if_recall, new_front in; ret_*, al_back_ptr out).
module retire_stage #(
  parameter int AL_SIZE = 32
) (
  input logic          clk,
  input logic          reset,
  retire_stage_if.slave rs
);
  localparam int P = $clog2(AL_SIZE);
  typedef logic [P-1:0] idx_t;

  logic [AL_SIZE-1:0] done_q;
  logic [AL_SIZE-1:0] done_d;
  idx_t               head_q;
  idx_t               head_p1;

  // Payload storage, unreset: only read when the matching done bit is set.
  logic               pay_uses_rd [AL_SIZE];
  logic [4:0]         pay_rd      [AL_SIZE];
  logic [31:0]        pay_data    [AL_SIZE];

  logic [3:0]         wb_keep;
  logic               ret0;
  logic               ret1;

  logic [1:0]         ret_valid_q;
  logic [1:0][P-1:0]  ret_al_idx_q;
  logic [1:0]         ret_uses_rd_q;
  logic [1:0][4:0]    ret_rd_q;
  logic [1:0][31:0]   ret_data_q;

  // Circular membership of idx in [lo, hi): distance from lo is below the range length.
  // lo == hi gives length 0, so nothing is squashed.
  function automatic logic squashed(idx_t idx, idx_t lo, idx_t hi, logic en);
    idx_t off;
    idx_t len;
    off = idx - lo;
    len = hi - lo;
    return en && (off < len);
  endfunction

  assign head_p1 = head_q + idx_t'(1);

  // Retire decision from pre-edge state; slot 1 only behind a retiring slot 0.
  always_comb begin
    ret0 = (head_q != rs.al_front_ptr) && done_q[head_q] &&
           !squashed(head_q, rs.new_front, rs.al_front_ptr, rs.if_recall);
    ret1 = ret0 && (head_p1 != rs.al_front_ptr) && done_q[head_p1] &&
           !squashed(head_p1, rs.new_front, rs.al_front_ptr, rs.if_recall);
  end

  // Next done vector: set by surviving writebacks, cleared by retire and by recall squash.
  always_comb begin
    done_d  = done_q;
    wb_keep = '0;
    for (int k = 0; k < 4; k++) begin
      wb_keep[k] = rs.wb_valid[k] &&
                   !squashed(rs.wb_al_idx[k], rs.new_front, rs.al_front_ptr, rs.if_recall);
      if (wb_keep[k]) done_d[rs.wb_al_idx[k]] = 1'b1;
    end
    if (ret0) done_d[head_q]  = 1'b0;
    if (ret1) done_d[head_p1] = 1'b0;
    for (int i = 0; i < AL_SIZE; i++) begin
      if (squashed(idx_t'(i), rs.new_front, rs.al_front_ptr, rs.if_recall)) done_d[i] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (wb_keep[k]) begin
        pay_uses_rd[rs.wb_al_idx[k]] <= rs.wb_uses_rd[k];
        pay_rd[rs.wb_al_idx[k]]      <= rs.wb_rd[k];
        pay_data[rs.wb_al_idx[k]]    <= rs.wb_data[k];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q        <= '0;
      done_q        <= '0;
      ret_valid_q   <= '0;
      ret_al_idx_q  <= '0;
      ret_uses_rd_q <= '0;
      ret_rd_q      <= '0;
      ret_data_q    <= '0;
    end else begin
      done_q      <= done_d;
      head_q      <= ret1 ? head_q + idx_t'(2) : (ret0 ? head_p1 : head_q);
      ret_valid_q <= {ret1, ret0};
      ret_al_idx_q <= {head_p1, head_q};
      // Payload is zeroed on idle slots so never-written entries cannot leak X onto ret_*.
      ret_uses_rd_q <= {ret1 && pay_uses_rd[head_p1], ret0 && pay_uses_rd[head_q]};
      ret_rd_q[0]   <= ret0 ? pay_rd[head_q]    : 5'd0;
      ret_rd_q[1]   <= ret1 ? pay_rd[head_p1]   : 5'd0;
      ret_data_q[0] <= ret0 ? pay_data[head_q]  : 32'd0;
      ret_data_q[1] <= ret1 ? pay_data[head_p1] : 32'd0;
    end
  end

  assign rs.ret_valid   = ret_valid_q;
  assign rs.ret_al_idx  = ret_al_idx_q;
  assign rs.ret_uses_rd = ret_uses_rd_q;
  assign rs.ret_rd      = ret_rd_q;
  assign rs.ret_data    = ret_data_q;
  assign rs.al_back_ptr = head_q;
endmodule

// File: tb/tb_retire_stage.sv
// Bench for retire_stage: directed scenarios then randomized traffic against an active-list reference model.
module tb_retire_stage;
  localparam int N = 16;
  localparam int P = 4;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  int   front;

  // Reference model: plain per-index arrays plus an integer head.
  bit          m_done [N];
  bit          m_uses [N];
  logic [4:0]  m_rd   [N];
  logic [31:0] m_data [N];
  int          m_head;

  retire_stage_if #(.AL_SIZE(N)) rif ();
  retire_stage #(.AL_SIZE(N)) dut (.clk(clk), .reset(reset), .rs(rif.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit in_sq(int i, int nf, int fr);
    return ((i - nf + N) % N) < ((fr - nf + N) % N);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_done[i] = 1'b0;
    m_head = 0;
  endtask

  task automatic idle();
    rif.wb_valid   = '0;
    rif.wb_al_idx  = '0;
    rif.wb_uses_rd = '0;
    rif.wb_rd      = '0;
    rif.wb_data    = '0;
    rif.if_recall  = 1'b0;
    rif.new_front  = '0;
  endtask

  task automatic set_front(input int f);
    front = f % N;
    rif.al_front_ptr = front[P-1:0];
  endtask

  task automatic set_wb(input int k, input int idx, input logic [31:0] d, input bit u, input logic [4:0] rd);
    rif.wb_valid[k]   = 1'b1;
    rif.wb_al_idx[k]  = idx[P-1:0];
    rif.wb_uses_rd[k] = u;
    rif.wb_rd[k]      = rd;
    rif.wb_data[k]    = d;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, 64'(rif.ret_valid), 64'd0);
    chk({tag, "_idx"},   64'(rif.ret_al_idx), 64'd0);
    chk({tag, "_uses"},  64'(rif.ret_uses_rd), 64'd0);
    chk({tag, "_rd"},    64'(rif.ret_rd), 64'd0);
    chk({tag, "_data"},  64'(rif.ret_data), 64'd0);
    chk({tag, "_back"},  64'(rif.al_back_ptr), 64'd0);
  endtask

  // Reset applied between edges; outputs must clear before any edge arrives.
  task automatic do_reset(input string tag);
    reset = 1'b1;
    idle();
    #1;
    chk_zero(tag);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // One clock: predict from the model using the inputs now applied, advance, compare.
  task automatic step();
    int fr, nf, h1, ix;
    bit rec, r0, r1;
    int          e_idx  [2];
    bit          e_uses [2];
    logic [4:0]  e_rd   [2];
    logic [31:0] e_data [2];
    fr  = int'(rif.al_front_ptr);
    nf  = int'(rif.new_front);
    rec = rif.if_recall;
    h1  = (m_head + 1) % N;
    r0  = (m_head != fr) && m_done[m_head] && !(rec && in_sq(m_head, nf, fr));
    r1  = r0 && (h1 != fr) && m_done[h1] && !(rec && in_sq(h1, nf, fr));
    e_idx[0] = m_head; e_uses[0] = m_uses[m_head]; e_rd[0] = m_rd[m_head]; e_data[0] = m_data[m_head];
    e_idx[1] = h1;     e_uses[1] = m_uses[h1];     e_rd[1] = m_rd[h1];     e_data[1] = m_data[h1];
    for (int k = 0; k < 4; k++) begin
      ix = int'(rif.wb_al_idx[k]);
      if (rif.wb_valid[k] && !(rec && in_sq(ix, nf, fr))) begin
        m_done[ix] = 1'b1;
        m_uses[ix] = rif.wb_uses_rd[k];
        m_rd[ix]   = rif.wb_rd[k];
        m_data[ix] = rif.wb_data[k];
      end
    end
    if (r0) m_done[m_head] = 1'b0;
    if (r1) m_done[h1] = 1'b0;
    if (rec) for (int i = 0; i < N; i++) if (in_sq(i, nf, fr)) m_done[i] = 1'b0;
    m_head = (m_head + int'(r0) + int'(r1)) % N;
    @(posedge clk);
    #1;
    chk("m_valid", 64'(rif.ret_valid), 64'({r1, r0}));
    for (int s = 0; s < 2; s++) begin
      if ((s == 0) ? r0 : r1) begin
        chk($sformatf("m_idx%0d", s),  64'(rif.ret_al_idx[s]), 64'(e_idx[s]));
        chk($sformatf("m_uses%0d", s), 64'(rif.ret_uses_rd[s]), 64'(e_uses[s]));
        chk($sformatf("m_rd%0d", s),   64'(rif.ret_rd[s]), 64'(e_rd[s]));
        chk($sformatf("m_data%0d", s), 64'(rif.ret_data[s]), 64'(e_data[s]));
      end
    end
    chk("m_back", 64'(rif.al_back_ptr), 64'(m_head));
  endtask

  initial begin
    int occ, nf, idx, off;
    bit rec, ok;
    int used [4];
    checks = 0;
    failures = 0;
    reset = 1'b1;
    idle();
    set_front(0);
    model_reset();
    #1;
    chk_zero("por");
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Two writebacks at one edge retire together two edges later.
    set_front(2);
    set_wb(0, 0, 32'h11, 1'b1, 5'd3);
    set_wb(2, 1, 32'h22, 1'b1, 5'd7);
    step();
    chk("basic_latency", 64'(rif.ret_valid), 64'd0);
    idle();
    step();
    chk("basic_valid", 64'(rif.ret_valid), 64'b11);
    chk("basic_idx0", 64'(rif.ret_al_idx[0]), 64'd0);
    chk("basic_idx1", 64'(rif.ret_al_idx[1]), 64'd1);
    chk("basic_data0", 64'(rif.ret_data[0]), 64'h11);
    chk("basic_data1", 64'(rif.ret_data[1]), 64'h22);
    chk("basic_back", 64'(rif.al_back_ptr), 64'd2);

    // Younger entries done but head not: nothing retires until head completes.
    do_reset("rst_a");
    set_front(3);
    set_wb(0, 1, 32'hA1, 1'b1, 5'd1);
    set_wb(3, 2, 32'hA2, 1'b0, 5'd2);
    step();
    idle();
    step();
    chk("order_blk_valid", 64'(rif.ret_valid), 64'd0);
    chk("order_blk_back", 64'(rif.al_back_ptr), 64'd0);
    set_wb(1, 0, 32'hA0, 1'b1, 5'd9);
    step();
    idle();
    step();
    chk("order_valid", 64'(rif.ret_valid), 64'b11);
    chk("order_idx0", 64'(rif.ret_al_idx[0]), 64'd0);
    chk("order_idx1", 64'(rif.ret_al_idx[1]), 64'd1);
    step();
    chk("order_tail_valid", 64'(rif.ret_valid), 64'b01);
    chk("order_tail_idx", 64'(rif.ret_al_idx[0]), 64'd2);
    chk("order_tail_back", 64'(rif.al_back_ptr), 64'd3);

    // Recall squashes [2,6): idx4 writeback is dropped, only 0 and 1 retire.
    do_reset("rst_b");
    set_front(6);
    for (int k = 0; k < 4; k++) set_wb(k, k + 2, 32'hB0 + k, 1'b1, 5'(k));
    step();
    idle();
    set_wb(0, 0, 32'hC0, 1'b1, 5'd10);
    set_wb(2, 1, 32'hC1, 1'b1, 5'd11);
    step();
    idle();
    rif.if_recall = 1'b1;
    rif.new_front = 4'd2;
    set_wb(1, 4, 32'hDEAD, 1'b1, 5'd12);
    step();
    chk("recall_valid", 64'(rif.ret_valid), 64'b11);
    chk("recall_idx0", 64'(rif.ret_al_idx[0]), 64'd0);
    chk("recall_idx1", 64'(rif.ret_al_idx[1]), 64'd1);
    idle();
    set_front(2);
    step();
    chk("recall_empty", 64'(rif.ret_valid), 64'd0);
    set_front(5);
    step();
    step();
    chk("recall_stale", 64'(rif.ret_valid), 64'd0);
    set_wb(3, 2, 32'hE2, 1'b0, 5'd13);
    step();
    idle();
    step();
    chk("recall_refill", 64'(rif.ret_valid), 64'b01);
    chk("recall_refill_idx", 64'(rif.ret_al_idx[0]), 64'd2);

    // Wrap: head at N-1 pairs with index 0.
    do_reset("rst_c");
    set_front(N - 1);
    for (int c = 0; c < 4; c++) begin
      idle();
      for (int k = 0; k < 4; k++) if (4 * c + k < N - 1) set_wb(k, 4 * c + k, $urandom, 1'b1, 5'($urandom));
      step();
    end
    idle();
    for (int i = 0; i < 30 && int'(rif.al_back_ptr) != N - 1; i++) step();
    chk("wrap_head", 64'(rif.al_back_ptr), 64'(N - 1));
    set_front(1);
    set_wb(0, N - 1, 32'hAA, 1'b1, 5'd30);
    set_wb(3, 0, 32'hBB, 1'b0, 5'd31);
    step();
    idle();
    step();
    chk("wrap_valid", 64'(rif.ret_valid), 64'b11);
    chk("wrap_idx0", 64'(rif.ret_al_idx[0]), 64'(N - 1));
    chk("wrap_idx1", 64'(rif.ret_al_idx[1]), 64'd0);
    chk("wrap_data0", 64'(rif.ret_data[0]), 64'hAA);
    chk("wrap_data1", 64'(rif.ret_data[1]), 64'hBB);
    chk("wrap_back", 64'(rif.al_back_ptr), 64'd1);

    // Reset between edges while both slots valid; pending done bits must not survive.
    do_reset("rst_d");
    set_front(4);
    set_wb(0, 0, 32'h1, 1'b1, 5'd1);
    set_wb(1, 1, 32'h2, 1'b1, 5'd2);
    set_wb(2, 3, 32'h3, 1'b1, 5'd3);
    step();
    idle();
    step();
    chk("async_pre_valid", 64'(rif.ret_valid), 64'b11);
    #1;
    do_reset("async");
    for (int i = 0; i < 3; i++) begin
      step();
      chk("async_stale", 64'(rif.ret_valid), 64'd0);
    end
    set_wb(2, 0, 32'h77, 1'b1, 5'd4);
    step();
    idle();
    step();
    chk("async_fresh_valid", 64'(rif.ret_valid), 64'b01);
    chk("async_fresh_data", 64'(rif.ret_data[0]), 64'h77);

    // Empty with every done bit set: no retire; each index written from every port.
    do_reset("rst_e");
    set_front(0);
    for (int r = 0; r < 4; r++) begin
      for (int j = 0; j < 4; j++) begin
        idle();
        for (int k = 0; k < 4; k++) set_wb(k, 4 * j + (k + r) % 4, $urandom, 1'($urandom), 5'($urandom));
        step();
        chk("empty_valid", 64'(rif.ret_valid), 64'd0);
      end
    end
    idle();
    step();
    chk("empty_back", 64'(rif.al_back_ptr), 64'd0);
    set_front(1);
    step();
    chk("full1_valid", 64'(rif.ret_valid), 64'b01);
    chk("full1_idx", 64'(rif.ret_al_idx[0]), 64'd0);
    set_front(0);
    for (int i = 0; i < 10; i++) step();
    chk("full_drain_back", 64'(rif.al_back_ptr), 64'd0);

    // Randomized traffic with allocation, overwrites and recalls.
    do_reset("rst_r");
    set_front(0);
    for (int cyc = 0; cyc < 1500; cyc++) begin
      idle();
      occ = (front - m_head + N) % N;
      rec = (occ > 0) && ($urandom_range(0, 19) == 0);
      nf = front;
      if (rec) begin
        nf = (m_head + int'($urandom_range(0, occ))) % N;
        rif.if_recall = 1'b1;
        rif.new_front = nf[P-1:0];
      end else begin
        idx = int'($urandom_range(0, 2));
        if (occ + idx <= N - 1) set_front(front + idx);
        occ = (front - m_head + N) % N;
      end
      for (int k = 0; k < 4; k++) begin
        used[k] = -1;
        if (occ > 0 && $urandom_range(0, 1) == 1) begin
          idx = (m_head + int'($urandom_range(0, occ - 1))) % N;
          off = (idx - m_head + N) % N;
          ok = !(off < 2 && m_done[idx]);
          for (int j = 0; j < k; j++) if (used[j] == idx) ok = 1'b0;
          if (ok) begin
            used[k] = idx;
            set_wb(k, idx, $urandom, 1'($urandom), 5'($urandom));
          end
        end
      end
      step();
      if (rec) set_front(nf);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
